panic_class_scheduler: RTL and testbench
========================================

Name: panic_class_scheduler

Overview:
- Packet-atomic, credit-based weighted round-robin scheduler that shares one RX AXI-stream egress (toward the DMA) between NUM_CLASS per-flow-class input streams.
- Each class gets a per-epoch beat budget from configuration. Epoch length matches the perf-counter sampling interval, so measured per-class Gbps can be checked against the programmed weights.
- Sits between the per-class queues and the DMA RX port, upstream of the perf counter taps.

Parameters:
- AXIS_DATA_WIDTH, 512, data width per stream in bits.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- NUM_CLASS, 3, number of flow-class inputs (2..8).
- EPOCH_LOG2, 10, epoch length is 2^EPOCH_LOG2 cycles.
- CREDIT_WIDTH, 16, width of configured credit (unit: beats).
- WORK_CONSERVING, 0, 1 = grant out-of-credit classes when no in-credit class is ready.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset (asserted at 0)
- s_axis_tdata  input  NUM_CLASS*AXIS_DATA_WIDTH  per-class data, class i at slice i
- s_axis_tkeep  input  NUM_CLASS*AXIS_KEEP_WIDTH  per-class keep
- s_axis_tvalid  input  NUM_CLASS  per-class valid
- s_axis_tlast  input  NUM_CLASS  per-class last
- s_axis_tready  output  NUM_CLASS  per-class ready
- m_axis_tdata  output  AXIS_DATA_WIDTH  egress data
- m_axis_tkeep  output  AXIS_KEEP_WIDTH  egress keep
- m_axis_tvalid  output  1  egress valid
- m_axis_tlast  output  1  egress last
- m_axis_tready  input  1  egress ready
- cfg_credit  input  NUM_CLASS*CREDIT_WIDTH  per-class beats per epoch, sampled at each epoch reload
- grant_valid  output  1  a packet is in flight
- grant_class  output  clog2(NUM_CLASS)  class currently granted
- grant_bonus  output  1  current grant is a work-conserving (uncharged) grant
- epoch_tick  output  1  one-cycle pulse on the cycle credits reload

Behaviour:
- Reset (async assert, sync release). All outputs go to 0 immediately: tready, m_axis_tvalid, grant_*, epoch_tick. State = IDLE, epoch counter = 0, RR pointer = 0, credits = 0.
- Epoch counter: EPOCH_LOG2 bits, free-running, wraps. Reload happens on every cycle the counter is 0, including the first cycle after reset release. epoch_tick = 1 on that cycle.
- Credit per class: signed, CREDIT_WIDTH+1 bits.
  - Reload: credit <= cfg_credit[i] + min(credit_after_this_cycle_charge, 0).
  - Positive leftover is discarded; debt carries into the next epoch.
  - Result saturates at -2^CREDIT_WIDTH.
- Charge: one unit per accepted beat (m_axis_tvalid & m_axis_tready) of a non-bonus grant. Charge and reload in the same cycle are applied charge-first.
- Eligibility: class i is eligible if s_axis_tvalid[i] = 1 and credit[i] > 0.
- FSM IDLE:
  - Scan classes from the RR pointer upward (mod NUM_CLASS); first eligible class wins.
  - If none are eligible, WORK_CONSERVING = 1, and some tvalid is set: pick the first valid class in the same scan order, with bonus = 1.
  - On a win: register grant_class, set grant_valid, move RR pointer to winner+1 mod NUM_CLASS, go to XFER. Arbitration costs exactly one cycle; nothing transfers in IDLE.
- FSM XFER:
  - Combinational mux of the granted class onto m_axis_*: m_axis_tvalid = s_axis_tvalid[g], s_axis_tready[g] = m_axis_tready, all other tready = 0.
  - Grant is held until a beat with tlast is accepted, then return to IDLE with grant_valid = 0 and grant_bonus = 0 the next cycle.
  - Credit reaching 0 or below mid-packet never truncates the packet (overdraw becomes debt).
- Backpressure: m_axis_tready = 0 stalls with no charge and no grant change. The source must hold its data (AXIS rules).
- Source tvalid dropping mid-packet: output a bubble and keep the grant.
- cfg_credit = 0: the class is never eligible, but is still reachable through a bonus grant when WORK_CONSERVING = 1.
- Reset mid-packet: the partial packet is abandoned. Upstream flush is the system's responsibility. Arbitration restarts from class 0.
- No combinational path from m_axis_tready to m_axis_tvalid.

Test Plan (NUM_CLASS=3, EPOCH_LOG2=10):
- Only class 0 valid, cfg_credit=8, continuous 4-beat packets, WORK_CONSERVING=0 -> exactly 2 packets (8 beats) per epoch, one idle cycle between packets. Class 0 tready then stays 0 until the next epoch_tick.
- All classes backlogged with 1-beat packets, cfg 10/10/10 -> grant_class sequence 0,1,2,0,1,... and each class gets exactly 10 beats per epoch.
- Class 1 credit 2 starts a 5-beat packet -> all 5 beats pass and credit = -3. Next reload with cfg 10 -> credit 7.
- WORK_CONSERVING=1, all credits 0, only class 2 valid -> packet forwarded with grant_bonus = 1 and credit[2] stays 0. If class 0 becomes valid with credit > 0 mid-packet, class 0 wins the next arbitration.
- m_axis_tready held 0 for 5 cycles on beat 2 of a 4-beat class 1 packet -> m_axis_tdata stable, grant_class = 1 throughout, credit decremented by exactly 4 in total.
- rst driven 0 asynchronously during beat 2 of 4 -> m_axis_tvalid and all s_axis_tready go to 0 in the same cycle. After release: epoch_tick on the first cycle, first grant goes to class 0.

Source files
------------

// File: rtl/panic_class_scheduler.sv
// Packet-atomic, credit-based weighted round-robin scheduler: NUM_CLASS AXI-stream
// inputs share one egress, each class limited to a per-epoch beat budget.
module panic_class_scheduler #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int NUM_CLASS       = 3,
    parameter int EPOCH_LOG2      = 10,
    parameter int CREDIT_WIDTH    = 16,
    parameter bit WORK_CONSERVING = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CLASS*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CLASS*AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_CLASS-1:0]                 s_axis_tvalid,
    input  logic [NUM_CLASS-1:0]                 s_axis_tlast,
    output logic [NUM_CLASS-1:0]                 s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,
    input  logic [NUM_CLASS*CREDIT_WIDTH-1:0]    cfg_credit,
    output logic                                 grant_valid,
    output logic [$clog2(NUM_CLASS)-1:0]         grant_class,
    output logic                                 grant_bonus,
    output logic                                 epoch_tick
);
    localparam int CLS_W = $clog2(NUM_CLASS);
    localparam int CRD_W = CREDIT_WIDTH + 1;
    localparam int EXT_W = CRD_W + 2;
    localparam logic signed [EXT_W-1:0] CRD_MIN  = {3'b111, {CREDIT_WIDTH{1'b0}}};
    localparam logic signed [EXT_W-1:0] CRD_MAX  = {3'b000, {CREDIT_WIDTH{1'b1}}};
    localparam logic signed [EXT_W-1:0] CRD_ZERO = '0;

    typedef enum logic {IDLE, XFER} state_e;

    state_e                  state_q, state_d;
    logic [EPOCH_LOG2-1:0]   epoch_q, epoch_d;
    logic [CLS_W-1:0]        rr_q, rr_d;
    logic [CLS_W-1:0]        grant_class_q, grant_class_d;
    logic                    bonus_q, bonus_d;
    logic signed [CRD_W-1:0] credit_q [NUM_CLASS];
    logic signed [CRD_W-1:0] credit_d [NUM_CLASS];

    logic                    xfer;
    logic                    reload;
    logic                    beat_acc;
    logic                    charge_en;
    logic [NUM_CLASS-1:0]    eligible;
    logic                    win_found;
    logic [CLS_W-1:0]        win_cls;
    logic                    win_bonus;
    logic signed [EXT_W-1:0] charged;
    logic signed [EXT_W-1:0] refilled;

    function automatic logic [CLS_W-1:0] scan_idx(input logic [CLS_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_CLASS) s = s - NUM_CLASS;
        return CLS_W'(s);
    endfunction

    // Debt floor is -2^CREDIT_WIDTH; the upper clamp only guards the field width.
    function automatic logic signed [CRD_W-1:0] sat_credit(input logic signed [EXT_W-1:0] v);
        logic signed [EXT_W-1:0] c;
        c = v;
        if (v < CRD_MIN) c = CRD_MIN;
        else if (v > CRD_MAX) c = CRD_MAX;
        return c[CRD_W-1:0];
    endfunction

    assign xfer      = (state_q == XFER);
    assign reload    = (epoch_q == '0);
    assign epoch_d   = epoch_q + 1'b1;
    assign beat_acc  = m_axis_tvalid & m_axis_tready;
    assign charge_en = beat_acc & ~bonus_q;

    assign m_axis_tvalid = xfer & s_axis_tvalid[grant_class_q];
    assign m_axis_tlast  = xfer & s_axis_tlast[grant_class_q];
    assign m_axis_tdata  = xfer ? s_axis_tdata[int'(grant_class_q)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] : '0;
    assign m_axis_tkeep  = xfer ? s_axis_tkeep[int'(grant_class_q)*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH] : '0;
    assign grant_valid   = xfer;
    assign grant_class   = grant_class_q;
    assign grant_bonus   = bonus_q;
    // Counter rests at 0 during reset, so the tick is masked until release.
    assign epoch_tick    = rst & reload;

    always_comb begin
        s_axis_tready = '0;
        if (xfer) s_axis_tready[grant_class_q] = m_axis_tready;
    end

    always_comb begin
        for (int i = 0; i < NUM_CLASS; i++) begin
            eligible[i] = s_axis_tvalid[i] && !credit_q[i][CRD_W-1] && (credit_q[i] != '0);
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_cls   = '0;
        win_bonus = 1'b0;
        for (int k = 0; k < NUM_CLASS; k++) begin
            if (!win_found && eligible[scan_idx(rr_q, k)]) begin
                win_found = 1'b1;
                win_cls   = scan_idx(rr_q, k);
            end
        end
        if (WORK_CONSERVING && !win_found) begin
            for (int k = 0; k < NUM_CLASS; k++) begin
                if (!win_found && s_axis_tvalid[scan_idx(rr_q, k)]) begin
                    win_found = 1'b1;
                    win_cls   = scan_idx(rr_q, k);
                    win_bonus = 1'b1;
                end
            end
        end
    end

    // Charge is applied before the epoch refill; only debt survives the refill.
    always_comb begin
        charged  = CRD_ZERO;
        refilled = CRD_ZERO;
        for (int i = 0; i < NUM_CLASS; i++) begin
            charged = $signed({{2{credit_q[i][CRD_W-1]}}, credit_q[i]})
                    - $signed({{(EXT_W-1){1'b0}}, charge_en && (grant_class_q == CLS_W'(i))});
            refilled = $signed({3'b000, cfg_credit[i*CREDIT_WIDTH +: CREDIT_WIDTH]})
                     + (charged[EXT_W-1] ? charged : CRD_ZERO);
            credit_d[i] = sat_credit(reload ? refilled : charged);
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        grant_class_d = grant_class_q;
        bonus_d       = bonus_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d       = XFER;
                    grant_class_d = win_cls;
                    bonus_d       = win_bonus;
                    rr_d          = scan_idx(win_cls, 1);
                end
            end
            XFER: begin
                if (beat_acc && m_axis_tlast) begin
                    state_d = IDLE;
                    bonus_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            epoch_q       <= '0;
            rr_q          <= '0;
            grant_class_q <= '0;
            bonus_q       <= 1'b0;
            for (int i = 0; i < NUM_CLASS; i++) credit_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            epoch_q       <= epoch_d;
            rr_q          <= rr_d;
            grant_class_q <= grant_class_d;
            bonus_q       <= bonus_d;
            for (int i = 0; i < NUM_CLASS; i++) credit_q[i] <= credit_d[i];
        end
    end

endmodule

// File: tb/tb_panic_class_scheduler.sv
// Directed bench for panic_class_scheduler: one strict and one work-conserving
// instance share the stimulus; sel_wc picks which one the sources and checks follow.
module tb_panic_class_scheduler;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int NC = 3;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NC*DW-1:0] s_tdata;
    logic [NC*KW-1:0] s_tkeep;
    logic [NC-1:0]    s_tvalid;
    logic [NC-1:0]    s_tlast;
    logic             m_tready;
    logic [NC*CW-1:0] cfg;
    logic             sel_wc;

    wire [NC-1:0] tr_a, tr_b;
    wire [DW-1:0] md_a, md_b;
    wire [KW-1:0] mk_a, mk_b;
    wire          mv_a, mv_b, ml_a, ml_b, gv_a, gv_b, gb_a, gb_b, et_a, et_b;
    wire [1:0]    gc_a, gc_b;

    wire [NC-1:0] s_tready    = sel_wc ? tr_b : tr_a;
    wire [DW-1:0] m_tdata     = sel_wc ? md_b : md_a;
    wire          m_tvalid    = sel_wc ? mv_b : mv_a;
    wire          grant_valid = sel_wc ? gv_b : gv_a;
    wire [1:0]    grant_class = sel_wc ? gc_b : gc_a;
    wire          grant_bonus = sel_wc ? gb_b : gb_a;
    wire          epoch_tick  = sel_wc ? et_b : et_a;

    panic_class_scheduler #(
        .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .NUM_CLASS(NC),
        .EPOCH_LOG2(10), .CREDIT_WIDTH(CW), .WORK_CONSERVING(1'b0)
    ) u_dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(tr_a),
        .m_axis_tdata(md_a), .m_axis_tkeep(mk_a), .m_axis_tvalid(mv_a),
        .m_axis_tlast(ml_a), .m_axis_tready(m_tready),
        .cfg_credit(cfg), .grant_valid(gv_a), .grant_class(gc_a),
        .grant_bonus(gb_a), .epoch_tick(et_a)
    );

    panic_class_scheduler #(
        .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .NUM_CLASS(NC),
        .EPOCH_LOG2(10), .CREDIT_WIDTH(CW), .WORK_CONSERVING(1'b1)
    ) u_dut_wc (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(tr_b),
        .m_axis_tdata(md_b), .m_axis_tkeep(mk_b), .m_axis_tvalid(mv_b),
        .m_axis_tlast(ml_b), .m_axis_tready(m_tready),
        .cfg_credit(cfg), .grant_valid(gv_b), .grant_class(gc_b),
        .grant_bonus(gb_b), .epoch_tick(et_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit src_on   [NC];
    int src_len  [NC];
    int src_beat [NC];
    int src_pkt  [NC];
    int src_lim  [NC];
    int beats    [2][NC];
    int nb       [2][NC];
    int seq      [$];

    logic          c_mv, c_gv, c_gb, c_et;
    logic [1:0]    c_gc;
    logic [DW-1:0] c_md;
    logic [NC-1:0] c_tr;
    logic [NC-1:0] fire;
    logic          late_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Each source emits back-to-back packets; beat data encodes class/packet/beat.
    task automatic drive_src();
        for (int i = 0; i < NC; i++) begin
            s_tvalid[i]           = src_on[i];
            s_tlast[i]            = (src_beat[i] == src_len[i] - 1);
            s_tdata[i*DW +: DW]   = {8'(i), 8'(src_pkt[i]), 16'(src_beat[i])};
            s_tkeep[i*KW +: KW]   = '1;
        end
    endtask

    task automatic snap(input int c);
        int e;
        drive_src();
        @(negedge clk);
        c_mv = m_tvalid;  c_gv = grant_valid; c_gb = grant_bonus; c_et = epoch_tick;
        c_gc = grant_class; c_md = m_tdata;   c_tr = s_tready;
        fire = s_tvalid & s_tready;
        if (c_mv && m_tready) begin
            e = c >> 10;
            if (e < 2) begin
                beats[e][int'(c_gc)]++;
                if (!c_gb) nb[e][int'(c_gc)]++;
            end
            seq.push_back(int'(c_gc));
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (fire[i]) begin
                if (src_beat[i] == src_len[i] - 1) begin
                    src_beat[i] = 0;
                    src_pkt[i]++;
                    if (src_lim[i] != 0 && src_pkt[i] >= src_lim[i]) src_on[i] = 1'b0;
                end else begin
                    src_beat[i]++;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < NC; i++) begin
            src_beat[i] = 0;
            src_pkt[i]  = 0;
            for (int e = 0; e < 2; e++) begin
                beats[e][i] = 0;
                nb[e][i]    = 0;
            end
        end
        seq.delete();
        drive_src();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        // Reset state, then A: lone class 0, 8 credits, 4-beat packets, strict mode
        sel_wc = 1'b0; m_tready = 1'b1;
        cfg = {16'd0, 16'd0, 16'd8};
        src_on  = '{1'b1, 1'b0, 1'b0};
        src_len = '{4, 4, 4};
        src_lim = '{0, 0, 0};
        for (int i = 0; i < NC; i++) begin src_beat[i] = 0; src_pkt[i] = 0; end
        drive_src();
        #2;
        chk("reset_outputs", 64'({m_tvalid, s_tready, grant_valid, grant_class, grant_bonus, epoch_tick}), 64'd0);
        do_reset();
        late_rdy = 1'b0;
        for (int c = 0; c < 1040; c++) begin
            snap(c);
            if (c == 0)    chk("A_tick_after_release", 64'(c_et), 64'd1);
            if (c == 1)    chk("A_arb_cycle_idle", 64'({c_et, c_mv, c_gv}), 64'd0);
            if (c == 2)    chk("A_first_beat", 64'({c_gv, c_mv, c_tr[0], c_gc}), 64'b11100);
            if (c == 6)    chk("A_gap_between_pkts", 64'(c_mv), 64'd0);
            if (c == 7)    chk("A_second_pkt", 64'(c_mv), 64'd1);
            if (c >= 11 && c < 1024) late_rdy = late_rdy | c_tr[0];
            if (c == 1024) chk("A_tick_epoch1", 64'(c_et), 64'd1);
            adv();
        end
        chk("A_beats_epoch0", 64'(beats[0][0]), 64'd8);
        chk("A_ready_low_until_tick", 64'(late_rdy), 64'd0);
        chk("A_beats_epoch1", 64'(beats[1][0]), 64'd8);

        // B: all classes backlogged with 1-beat packets, 10 credits each
        cfg = {16'd10, 16'd10, 16'd10};
        src_on  = '{1'b1, 1'b1, 1'b1};
        src_len = '{1, 1, 1};
        do_reset();
        for (int c = 0; c < 2048; c++) begin
            snap(c);
            adv();
        end
        for (int k = 0; k < 6; k++) chk($sformatf("B_rr_order_%0d", k), 64'(seq[k]), 64'(k % 3));
        for (int i = 0; i < NC; i++) begin
            chk($sformatf("B_beats_ep0_cls%0d", i), 64'(beats[0][i]), 64'd10);
            chk($sformatf("B_beats_ep1_cls%0d", i), 64'(beats[1][i]), 64'd10);
        end

        // C: overdraw becomes debt; unused positive credit is dropped at reload
        cfg = {16'd5, 16'd2, 16'd0};
        src_on  = '{1'b0, 1'b1, 1'b0};
        src_len = '{1, 5, 1};
        do_reset();
        for (int c = 0; c < 2048; c++) begin
            if (c == 500) begin
                src_len[1] = 1;
                cfg[1*CW +: CW] = 16'd10;
            end
            if (c == 1030) src_on[2] = 1'b1;
            snap(c);
            adv();
        end
        chk("C_packet_not_truncated", 64'(beats[0][1]), 64'd5);
        chk("C_debt_carried", 64'(beats[1][1]), 64'd7);
        chk("C_leftover_discarded", 64'(beats[1][2]), 64'd5);

        // D: egress stall on beat 2 of a 4-beat class 1 packet
        cfg = {16'd0, 16'd10, 16'd0};
        src_on  = '{1'b0, 1'b1, 1'b0};
        src_len = '{4, 4, 4};
        do_reset();
        for (int c = 0; c < 1024; c++) begin
            m_tready = !(c >= 3 && c <= 7);
            if (c == 11) src_len[1] = 1;
            snap(c);
            if (c >= 3 && c <= 7)
                chk($sformatf("D_stall_hold_c%0d", c), 64'({c_mv, c_gc, c_tr[1], c_md}),
                    64'({1'b1, 2'd1, 1'b0, 8'd1, 8'd0, 16'd1}));
            if (c == 8) chk("D_resume", 64'({c_mv, c_tr[1], c_md}), 64'({1'b1, 1'b1, 8'd1, 8'd0, 16'd1}));
            adv();
        end
        m_tready = 1'b1;
        chk("D_charge_total", 64'(beats[0][1]), 64'd10);

        // E: work-conserving instance, bonus grants are uncharged
        sel_wc = 1'b1;
        cfg = {16'd0, 16'd0, 16'd4};
        src_on  = '{1'b0, 1'b0, 1'b1};
        src_len = '{4, 1, 3};
        src_lim = '{1, 0, 0};
        do_reset();
        for (int c = 0; c < 2048; c++) begin
            if (c == 2)   src_on[0] = 1'b1;
            if (c == 600) cfg[2*CW +: CW] = 16'd3;
            snap(c);
            if (c == 1) chk("E_bonus_grant", 64'({c_mv, c_gb, c_gc}), 64'({1'b1, 1'b1, 2'd2}));
            if (c == 5) chk("E_credited_class_wins", 64'({c_mv, c_gb, c_gc}), 64'({1'b1, 1'b0, 2'd0}));
            adv();
        end
        chk("E_class0_charged_beats", 64'(nb[0][0]), 64'd4);
        chk("E_class2_no_charged_ep0", 64'(nb[0][2]), 64'd0);
        chk("E_class2_credit_intact", 64'(nb[1][2]), 64'd3);

        // F: asynchronous reset mid-packet, then restart from class 0
        sel_wc = 1'b0;
        cfg = {16'd10, 16'd10, 16'd10};
        src_on  = '{1'b0, 1'b1, 1'b0};
        src_len = '{4, 4, 4};
        src_lim = '{0, 0, 0};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            snap(c);
            adv();
        end
        drive_src();
        #1;
        chk("F_mid_packet", 64'({m_tvalid, grant_class}), 64'({1'b1, 2'd1}));
        #1;
        rst = 1'b0;
        #1;
        chk("F_async_reset_outputs", 64'({m_tvalid, s_tready, grant_valid, grant_bonus, epoch_tick}), 64'd0);
        src_on = '{1'b1, 1'b1, 1'b1};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            snap(c);
            if (c == 0) chk("F_tick_after_release", 64'(c_et), 64'd1);
            if (c == 2) chk("F_first_grant_class0", 64'({c_mv, c_gc}), 64'({1'b1, 2'd0}));
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
